mem_port_arbiter: RTL

- Shares one single-port unified memory between the instruction-fetch stage and the data-memory stage of the 16-bit CPU.
- Sequences each access through a small FSM, with one transaction outstanding at a time.
- Data accesses win by fixed priority, and a starvation counter guarantees fetch progress.
- Accepts the CPU halt request and drains cleanly before freezing the memory port.

---
 rtl/mem_port_arbiter_if.sv | 36 +++
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle for the arbiter: CPU fetch/data request channels, halt control and the memory port.
// Handshake: a requester raises *_req with stable address/data and holds it until its one-cycle
// *_ack; the ack cycle already samples req again, so req must drop there unless a back-to-back
// access is wanted. mem_en is a one-cycle strobe; read data must be valid MEM_LAT cycles later.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              halt_req;
  logic              halted;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt_req, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, halted, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, halt_req, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, halted, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for a single-port memory: one transaction in flight, data priority with a
// fetch starvation guard, halt drain. Define ARB_PERF_CNT_EN to add grant/wait perf counters.
module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  mem_port_arbiter_if.slave                   bus,
`ifdef ARB_PERF_CNT_EN
  output logic [15:0]                         perf_if_grants,
  output logic [15:0]                         perf_d_grants,
  output logic [15:0]                         perf_wait_cycles,
`endif
  output logic [1:0]                          dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]     dbg_starve_cnt
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [SW-1:0]    STARVE_C = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    HALTED  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                owner_q, owner_d;   // 1 = data stage owns the access
  logic                if_ack_q, if_ack_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                d_ack_q, d_ack_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                halted_q, halted_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                wr_pending;
  logic                grant_d;
  logic                grant_f;

  // A write strobed last cycle is acked now; no new grant may overlap that ack.
  assign wr_pending = mem_en_q & mem_we_q;

  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    starve_d    = starve_q;
    owner_d     = owner_q;
    if_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_ack_d     = 1'b0;
    d_rdata_d   = d_rdata_q;
    halted_d    = halted_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    grant_d     = 1'b0;
    grant_f     = 1'b0;

    case (state_q)
      IDLE: begin
        d_ack_d = wr_pending;
        if (bus.halt_req) begin
          state_d  = HALTED;
          halted_d = 1'b1;
        end else if (!wr_pending) begin
          grant_d = bus.d_req && (!bus.if_req || (starve_q < STARVE_C));
          grant_f = bus.if_req && !grant_d;
          if (grant_d) begin
            mem_en_d    = 1'b1;
            mem_we_d    = bus.d_we;
            mem_addr_d  = bus.d_addr;
            mem_wdata_d = bus.d_wdata;
            owner_d     = 1'b1;
          end else if (grant_f) begin
            mem_en_d    = 1'b1;
            mem_addr_d  = bus.if_addr;
            owner_d     = 1'b0;
          end
          if (grant_d && bus.if_req) begin
            if (starve_q != STARVE_C) starve_d = starve_q + 1'b1;
          end else if (grant_d || grant_f) begin
            starve_d = '0;
          end
          if (mem_en_d && !mem_we_d) begin
            state_d = RD_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end

      RD_WAIT: begin
        if (lat_q == '0) begin
          if (owner_q) begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus.mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
          // Halt requested while the read was in flight: freeze on the ack edge.
          if (bus.halt_req) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end

      HALTED: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      starve_q    <= '0;
      owner_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_ack_q     <= 1'b0;
      d_rdata_q   <= '0;
      halted_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      if_ack_q    <= if_ack_d;
      if_rdata_q  <= if_rdata_d;
      d_ack_q     <= d_ack_d;
      d_rdata_q   <= d_rdata_d;
      halted_q    <= halted_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.halted    = halted_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_if_q, perf_if_d;
  logic [15:0] perf_dg_q, perf_dg_d;
  logic [15:0] perf_wait_q, perf_wait_d;
  logic        wait_now;

  always_comb begin
    wait_now    = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
    perf_if_d   = perf_if_q;
    perf_dg_d   = perf_dg_q;
    perf_wait_d = perf_wait_q;
    if (grant_f && (perf_if_q != 16'hFFFF))     perf_if_d   = perf_if_q + 16'd1;
    if (grant_d && (perf_dg_q != 16'hFFFF))     perf_dg_d   = perf_dg_q + 16'd1;
    if (wait_now && (perf_wait_q != 16'hFFFF))  perf_wait_d = perf_wait_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_q   <= '0;
      perf_dg_q   <= '0;
      perf_wait_q <= '0;
    end else begin
      perf_if_q   <= perf_if_d;
      perf_dg_q   <= perf_dg_d;
      perf_wait_q <= perf_wait_d;
    end
  end

  assign perf_if_grants   = perf_if_q;
  assign perf_d_grants    = perf_dg_q;
  assign perf_wait_cycles = perf_wait_q;
`endif

endmodule
